// File: rtl/cnn_image_sequencer.sv
// Buffers one image from a valid/ready byte stream, replays it into the CNN chip
// in raster order, and returns the chip's decision (or a watchdog timeout) over valid/ready.
module cnn_image_sequencer #(
    parameter int unsigned NPIX      = 784,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 chip_rst_n,
    output logic [DATA_BITS-1:0] chip_data,
    input  logic [3:0]           chip_decision,
    input  logic                 chip_valid,
    output logic [3:0]           res_decision,
    output logic                 res_timeout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy
);

    localparam int unsigned    WD       = $clog2(TIMEOUT);
    localparam logic [9:0]     LAST_IDX = 10'(NPIX - 1);
    localparam logic [WD-1:0]  WD_LAST  = WD'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, STREAM, WAIT, DONE} state_t;

    state_t               state, state_next;
    logic [DATA_BITS-1:0] mem [NPIX];
    logic [9:0]           wr_cnt, rd_cnt;
    logic [WD-1:0]        wdog;
    logic                 accept, last_byte, capture, expire;

    assign s_ready = (state == LOAD);
    assign busy    = (state != LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_next;
    end

    // A chip decision takes priority over a watchdog expiry on the same edge.
    always_comb begin
        state_next = state;
        accept     = s_valid && (state == LOAD);
        last_byte  = accept && (wr_cnt == LAST_IDX);
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            LOAD: if (last_byte) state_next = STREAM;
            STREAM, WAIT: begin
                capture = chip_valid;
                expire  = !chip_valid && (wdog == WD_LAST);
                if (capture || expire)
                    state_next = DONE;
                else if (state == STREAM && rd_cnt == LAST_IDX)
                    state_next = WAIT;
            end
            DONE: if (res_valid && res_ready) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_cnt] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            wdog         <= '0;
            chip_rst_n   <= 1'b0;
            chip_data    <= '0;
            res_valid    <= 1'b0;
            res_decision <= '0;
            res_timeout  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) wr_cnt <= wr_cnt + 10'd1;
                    if (last_byte) begin
                        chip_rst_n <= 1'b1;
                        rd_cnt     <= '0;
                        wdog       <= '0;
                    end
                end
                STREAM, WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (capture) begin
                        res_decision <= chip_decision;
                        res_timeout  <= 1'b0;
                        res_valid    <= 1'b1;
                        chip_rst_n   <= 1'b0;
                        chip_data    <= '0;
                    end else if (expire) begin
                        res_decision <= 4'hF;
                        res_timeout  <= 1'b1;
                        res_valid    <= 1'b1;
                        chip_rst_n   <= 1'b0;
                        chip_data    <= '0;
                    end else if (state == STREAM) begin
                        chip_data <= mem[rd_cnt];
                        rd_cnt    <= rd_cnt + 10'd1;
                    end else begin
                        chip_data <= '0;
                    end
                end
                DONE: begin
                    chip_rst_n <= 1'b0;
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        wr_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
